// File: rtl/div_unit_param_if.sv
// Operand/result bundle between the control unit and the sequential divider.
// The control side drives the request; the divider returns status and HI/LO results.
interface div_unit_param_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic             overflow;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    modport master (
        output start, is_signed, A, B,
        input  busy, done, div_by_zero, overflow, quotient, remainder
    );

    modport slave (
        input  start, is_signed, A, B,
        output busy, done, div_by_zero, overflow, quotient, remainder
    );
endinterface

// File: rtl/div_unit_param.sv
// Restoring sequential divider, signed (DIV) or unsigned (DIVU) per operation.
// One quotient bit per clock, then a sign-fix cycle; done lands WIDTH+1 edges after start.
module div_unit_param #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    div_unit_param_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int DW    = 2 * WIDTH;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONE_VAL  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x,
                                                  input logic             neg);
        return neg ? (~x + ONE_VAL) : x;
    endfunction

    logic [1:0]       state_q, state_d;
    logic [DW-1:0]    rem_q, rem_d;
    logic [DW-1:0]    dvs_q, dvs_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sq_q, sq_d;
    logic             sr_q, sr_d;
    logic             ovfp_q, ovfp_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] remo_q, remo_d;

    logic [DW-1:0]    dvs_shift;
    logic [DW:0]      diff;
    logic             borrow;
    logic             a_neg;
    logic             b_neg;

    // Shifting before subtracting makes exactly WIDTH iterations cover every quotient bit.
    assign dvs_shift = dvs_q >> 1;
    assign diff      = {1'b0, rem_q} - {1'b0, dvs_shift};
    assign borrow    = diff[DW];
    assign a_neg     = bus.is_signed & bus.A[WIDTH-1];
    assign b_neg     = bus.is_signed & bus.B[WIDTH-1];

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        sq_d    = sq_q;
        sr_d    = sr_q;
        ovfp_d  = ovfp_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;
        quot_d  = quot_q;
        remo_d  = remo_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.B == '0) begin
                        // Results hold; only the flags report the failed request.
                        done_d = 1'b1;
                        dbz_d  = 1'b1;
                        ovf_d  = 1'b0;
                    end else begin
                        sq_d    = a_neg ^ b_neg;
                        sr_d    = a_neg;
                        ovfp_d  = bus.is_signed & (bus.A == MIN_VAL) & (bus.B == '1);
                        rem_d   = {{WIDTH{1'b0}}, cond_neg(bus.A, a_neg)};
                        dvs_d   = {cond_neg(bus.B, b_neg), {WIDTH{1'b0}}};
                        quo_d   = '0;
                        cnt_d   = '0;
                        state_d = S_RUN;
                    end
                end
            end

            S_RUN: begin
                dvs_d = dvs_shift;
                if (!borrow) begin
                    rem_d = diff[DW-1:0];
                end
                quo_d = {quo_q[WIDTH-2:0], ~borrow};
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == LAST_CNT) begin
                    state_d = S_FIX;
                end
            end

            S_FIX: begin
                // MIN / -1 needs no special case: the magnitude path wraps to MIN, rem 0.
                quot_d  = cond_neg(quo_q, sq_q);
                remo_d  = cond_neg(rem_q[WIDTH-1:0], sr_q);
                done_d  = 1'b1;
                dbz_d   = 1'b0;
                ovf_d   = ovfp_q;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            sq_q    <= 1'b0;
            sr_q    <= 1'b0;
            ovfp_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
            quot_q  <= '0;
            remo_q  <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            sq_q    <= sq_d;
            sr_q    <= sr_d;
            ovfp_q  <= ovfp_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
            quot_q  <= quot_d;
            remo_q  <= remo_d;
        end
    end

    assign bus.busy        = (state_q != S_IDLE);
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.overflow    = ovf_q;
    assign bus.quotient    = quot_q;
    assign bus.remainder   = remo_q;
endmodule

// File: tb/tb_div_unit_param.sv
// Bench for div_unit_param at WIDTH=32 and WIDTH=8: vector table, scoreboard
// matched on done, latency and handshake sequences.
module tb_div_unit_param;
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
        logic        ovf;
    } vec_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    vec_t sb32[$];
    vec_t sb8[$];
    vec_t tbl[15];
    vec_t t8[5];

    div_unit_param_if #(.WIDTH(32)) bus32 ();
    div_unit_param_if #(.WIDTH(8))  bus8 ();

    div_unit_param #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(bus32));
    div_unit_param #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(bus8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input int u, input logic st, input logic [31:0] a,
                         input logic [31:0] b, input logic s);
        if (u == 0) begin
            bus32.start = st; bus32.A = a; bus32.B = b; bus32.is_signed = s;
        end else begin
            bus8.start = st; bus8.A = a[7:0]; bus8.B = b[7:0]; bus8.is_signed = s;
        end
    endtask

    function automatic logic get_done(input int u);
        return (u == 0) ? bus32.done : bus8.done;
    endfunction

    function automatic logic get_busy(input int u);
        return (u == 0) ? bus32.busy : bus8.busy;
    endfunction

    // Drives one request; poke>0 re-pulses start with junk operands while busy.
    task automatic run_op(input int u, input vec_t v, input int poke);
        int  w;
        int  k;
        bit  seen;
        w = (u == 0) ? 32 : 8;
        drive(u, 1'b1, v.a, v.b, v.s);
        if (u == 0) sb32.push_back(v); else sb8.push_back(v);
        @(posedge clk); #1;
        drive(u, 1'b0, $urandom, $urandom, 1'($urandom));
        if (v.dbz) begin
            chk("dbz_done_next_edge", {31'd0, get_done(u)}, 32'd1);
            chk("dbz_busy_low", {31'd0, get_busy(u)}, 32'd0);
        end else begin
            chk("busy_after_start", {31'd0, get_busy(u)}, 32'd1);
            chk("done_low_after_start", {31'd0, get_done(u)}, 32'd0);
            seen = 1'b0;
            for (k = 1; k <= 3 * w; k++) begin
                @(posedge clk); #1;
                if (get_done(u)) begin
                    seen = 1'b1;
                    break;
                end
                drive(u, (k == poke), $urandom, $urandom, 1'($urandom));
            end
            chk("done_latency", seen ? 32'(k) : 32'hFFFF_FFFF, 32'(w + 1));
            chk("busy_low_at_done", {31'd0, get_busy(u)}, 32'd0);
        end
    endtask

    always @(negedge clk) begin
        if (bus32.done === 1'b1) begin
            if (sb32.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done32 got done=1 expected done=0");
            end else begin
                vec_t e;
                e = sb32.pop_front();
                chk("quotient32", bus32.quotient, e.q);
                chk("remainder32", bus32.remainder, e.r);
                chk("div_by_zero32", {31'd0, bus32.div_by_zero}, {31'd0, e.dbz});
                chk("overflow32", {31'd0, bus32.overflow}, {31'd0, e.ovf});
            end
        end
        if (bus8.done === 1'b1) begin
            if (sb8.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done8 got done=1 expected done=0");
            end else begin
                vec_t e;
                e = sb8.pop_front();
                chk("quotient8", {24'd0, bus8.quotient}, {24'd0, e.q[7:0]});
                chk("remainder8", {24'd0, bus8.remainder}, {24'd0, e.r[7:0]});
                chk("div_by_zero8", {31'd0, bus8.div_by_zero}, {31'd0, e.dbz});
                chk("overflow8", {31'd0, bus8.overflow}, {31'd0, e.ovf});
            end
        end
    end

    initial begin
        int dcount;
        checks = 0;
        errors = 0;

        tbl[0]  = '{32'd100,      32'd7,        1'b1, 32'd14,       32'd2,        1'b0, 1'b0};
        tbl[1]  = '{32'hFFFFFFF9, 32'd2,        1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0};
        tbl[2]  = '{32'd7,        32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'd1,        1'b0, 1'b0};
        tbl[3]  = '{32'hFFFFFFF9, 32'hFFFFFFFE, 1'b1, 32'd3,        32'hFFFFFFFF, 1'b0, 1'b0};
        tbl[4]  = '{32'hFFFFFFFF, 32'h10,       1'b0, 32'h0FFFFFFF, 32'hF,        1'b0, 1'b0};
        tbl[5]  = '{32'hFFFFFFFF, 32'h10,       1'b1, 32'd0,        32'hFFFFFFFF, 1'b0, 1'b0};
        tbl[6]  = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0,        1'b0, 1'b1};
        tbl[7]  = '{32'd100,      32'd7,        1'b1, 32'd14,       32'd2,        1'b0, 1'b0};
        tbl[8]  = '{32'd5,        32'd0,        1'b1, 32'd14,       32'd2,        1'b1, 1'b0};
        tbl[9]  = '{32'h80000000, 32'hFFFFFFFF, 1'b0, 32'd0,        32'h80000000, 1'b0, 1'b0};
        tbl[10] = '{32'd12345,    32'd1,        1'b0, 32'd12345,    32'd0,        1'b0, 1'b0};
        tbl[11] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'd1,        32'd0,        1'b0, 1'b0};
        tbl[12] = '{32'd0,        32'd5,        1'b1, 32'd0,        32'd0,        1'b0, 1'b0};
        tbl[13] = '{32'h80000000, 32'd1,        1'b1, 32'h80000000, 32'd0,        1'b0, 1'b0};
        tbl[14] = '{32'hFFFFFF9C, 32'd7,        1'b1, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 1'b0};

        t8[0] = '{32'd200, 32'd3,  1'b0, 32'd66,  32'd2,  1'b0, 1'b0};
        t8[1] = '{32'h80,  32'hFF, 1'b1, 32'h80,  32'd0,  1'b0, 1'b1};
        t8[2] = '{32'hF9,  32'd2,  1'b1, 32'hFD,  32'hFF, 1'b0, 1'b0};
        t8[3] = '{32'd5,   32'd0,  1'b0, 32'hFD,  32'hFF, 1'b1, 1'b0};
        t8[4] = '{32'd200, 32'd3,  1'b1, 32'hEE,  32'hFE, 1'b0, 1'b0};

        drive(0, 1'b0, 32'd0, 32'd0, 1'b0);
        drive(1, 1'b0, 32'd0, 32'd0, 1'b0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, bus32.busy}, 32'd0);
        chk("rst_done", {31'd0, bus32.done}, 32'd0);
        chk("rst_quotient", bus32.quotient, 32'd0);
        chk("rst_remainder", bus32.remainder, 32'd0);
        chk("rst_dbz", {31'd0, bus32.div_by_zero}, 32'd0);
        chk("rst_ovf", {31'd0, bus32.overflow}, 32'd0);
        reset = 1'b0;

        // start re-pulsed mid-operation must leave the latched operands alone
        run_op(0, '{32'd1000, 32'd10, 1'b0, 32'd100, 32'd0, 1'b0, 1'b0}, 5);

        // reset in the middle of an operation aborts it without a done pulse
        drive(0, 1'b1, 32'd100, 32'd7, 1'b1);
        @(posedge clk); #1;
        drive(0, 1'b0, 32'd0, 32'd0, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_busy", {31'd0, bus32.busy}, 32'd0);
        chk("abort_done", {31'd0, bus32.done}, 32'd0);
        chk("abort_quotient", bus32.quotient, 32'd0);
        chk("abort_remainder", bus32.remainder, 32'd0);
        chk("abort_dbz", {31'd0, bus32.div_by_zero}, 32'd0);
        chk("abort_ovf", {31'd0, bus32.overflow}, 32'd0);
        dcount = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus32.done) dcount++;
        end
        chk("abort_no_done", 32'(dcount), 32'd0);

        // table runs back-to-back: each start is driven in the previous done cycle
        for (int i = 0; i < 15; i++) begin
            run_op(0, tbl[i], -1);
        end

        for (int i = 0; i < 5; i++) begin
            run_op(1, t8[i], (i == 0) ? 3 : -1);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("sb32_drained", 32'(sb32.size()), 32'd0);
        chk("sb8_drained", 32'(sb8.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
